// File: rtl/ncpu32k_idiv_if.sv
// Issue-queue-to-FU and writeback handshake bundle for the integer divider.
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

interface ncpu32k_idiv_if #(
    parameter int ROB_W = 4,
    parameter int UOP_W = 2,
    parameter int DW    = `NCPU_DW
);
    logic             fu_AVALID;
    logic             fu_AREADY;
    logic [ROB_W-1:0] fu_id;
    logic [UOP_W-1:0] fu_uop;
    logic [DW-1:0]    fu_rs1_dat;
    logic [DW-1:0]    fu_rs2_dat;
    logic             wb_BVALID;
    logic             wb_BREADY;
    logic [DW-1:0]    wb_BDATA;
    logic [ROB_W-1:0] wb_id;

    modport master (
        output fu_AVALID, fu_id, fu_uop, fu_rs1_dat, fu_rs2_dat, wb_BREADY,
        input  fu_AREADY, wb_BVALID, wb_BDATA, wb_id
    );

    modport slave (
        input  fu_AVALID, fu_id, fu_uop, fu_rs1_dat, fu_rs2_dat, wb_BREADY,
        output fu_AREADY, wb_BVALID, wb_BDATA, wb_id
    );
endinterface

// File: rtl/ncpu32k_idiv.sv
// Iterative 32-bit restoring divider FU: one op in flight, flushable.
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module ncpu32k_idiv #(
    parameter int CONFIG_ROB_DEPTH_LOG2 = 4,
    parameter int UOP_WIDTH             = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    ncpu32k_idiv_if.slave fu
);
    localparam int DW = `NCPU_DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [4:0]                       cnt_q, cnt_d;
    logic [CONFIG_ROB_DEPTH_LOG2-1:0] id_q, id_d;
    logic                             rsel_q, rsel_d;
    logic                             qneg_q, qneg_d;
    logic                             rneg_q, rneg_d;
    logic [DW-1:0]                    dvd_q, dvd_d;
    logic [DW-1:0]                    dvs_q, dvs_d;
    logic [DW-1:0]                    rem_q, rem_d;
    logic [DW-1:0]                    bdata_q, bdata_d;

    logic          accept;
    logic          sgn, remsel;
    logic          rs1_neg, rs2_neg;
    logic [DW-1:0] rs1, rs2;
    logic [DW-1:0] rs1_mag, rs2_mag;
    logic          div0, ovf;
    logic [DW-1:0] fast_res;

    assign rs1     = fu.fu_rs1_dat;
    assign rs2     = fu.fu_rs2_dat;
    assign sgn     = fu.fu_uop[0];
    assign remsel  = fu.fu_uop[1];
    assign rs1_neg = sgn & rs1[DW-1];
    assign rs2_neg = sgn & rs2[DW-1];
    assign rs1_mag = rs1_neg ? (DW'(0) - rs1) : rs1;
    assign rs2_mag = rs2_neg ? (DW'(0) - rs2) : rs2;
    assign div0    = (rs2 == '0);
    assign ovf     = sgn & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);

    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = remsel ? rs1 : '1;
        else
            fast_res = remsel ? '0 : 32'h8000_0000;
    end

    assign accept = (state_q == S_IDLE) & fu.fu_AVALID & ~i_flush;

    // One restoring step: trial-subtract the divisor from {rem, next dividend bit}
    logic [DW-1:0] part;
    logic          ge;
    logic [DW-1:0] sub;
    logic [DW-1:0] rem_n, dvd_n;
    logic [DW-1:0] res_sel, res;
    logic          res_neg;

    assign part    = {rem_q[DW-2:0], dvd_q[DW-1]};
    assign ge      = {rem_q, dvd_q[DW-1]} >= {1'b0, dvs_q};
    assign sub     = part - dvs_q;
    assign rem_n   = ge ? sub : part;
    assign dvd_n   = {dvd_q[DW-2:0], ge};
    assign res_sel = rsel_q ? rem_n : dvd_n;
    assign res_neg = rsel_q ? rneg_q : qneg_q;
    assign res     = res_neg ? (DW'(0) - res_sel) : res_sel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        rsel_d  = rsel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        bdata_d = bdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d   = fu.fu_id;
                    rsel_d = remsel;
                    qneg_d = rs1_neg ^ rs2_neg;
                    rneg_d = rs1_neg;
                    dvd_d  = rs1_mag;
                    dvs_d  = rs2_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (div0 | ovf) begin
                        bdata_d = fast_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_n;
                dvd_d = dvd_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    bdata_d = res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (fu.wb_BREADY)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            rsel_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            bdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rsel_q  <= rsel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            bdata_q <= bdata_d;
        end
    end

    assign fu.fu_AREADY = (state_q == S_IDLE);
    assign fu.wb_BVALID = (state_q == S_DONE);
    assign fu.wb_BDATA  = bdata_q;
    assign fu.wb_id     = id_q;
endmodule

// File: tb/tb_ncpu32k_idiv.sv
// Directed-vector bench for the iterative divider FU.
module tb_ncpu32k_idiv;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vec = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ncpu32k_idiv_if #(.ROB_W(4), .UOP_W(2)) bus ();

    ncpu32k_idiv #(
        .CONFIG_ROB_DEPTH_LOG2(4),
        .UOP_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_flush(flush),
        .fu(bus)
    );

    task automatic offer(input logic [1:0] uop, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] id);
        bus.fu_AVALID  = 1'b1;
        bus.fu_uop     = uop;
        bus.fu_rs1_dat = a;
        bus.fu_rs2_dat = b;
        bus.fu_id      = id;
        @(negedge clk);
        bus.fu_AVALID  = 1'b0;
    endtask

    // lat counts cycles from the accept edge to the first BVALID cycle
    task automatic wait_bv(output int lat);
        lat = 1;
        while (!bus.wb_BVALID && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        bus.wb_BREADY = 1'b1;
        @(negedge clk);
        bus.wb_BREADY = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] uop, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] id,
                         output logic [31:0] d, output logic [3:0] rid,
                         output int lat);
        offer(uop, a, b, id);
        wait_bv(lat);
        d   = bus.wb_BDATA;
        rid = bus.wb_id;
        consume();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vec++;
        if (bus.fu_AREADY !== 1'b1 || bus.wb_BVALID !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: ardy=%b bv=%b want 1 0",
                     bus.fu_AREADY, bus.wb_BVALID);
        end
        vec++;
        if (bus.wb_BDATA !== 32'h0 || bus.wb_id !== 4'h0) begin
            bad++;
            $display("FAIL reset_data: data=%h id=%h want 0 0",
                     bus.wb_BDATA, bus.wb_id);
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] d;
        logic [3:0]  id;
        int          lat;
        do_op(2'b00, 32'd100, 32'd7, 4'd3, d, id, lat);
        vec++;
        if (d !== 32'd14 || id !== 4'd3 || lat !== 33) begin
            bad++;
            $display("FAIL udiv_q: data=%0d id=%0d lat=%0d want 14 3 33", d, id, lat);
        end
        do_op(2'b10, 32'd100, 32'd7, 4'd5, d, id, lat);
        vec++;
        if (d !== 32'd2 || id !== 4'd5 || lat !== 33) begin
            bad++;
            $display("FAIL udiv_r: data=%0d id=%0d lat=%0d want 2 5 33", d, id, lat);
        end
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1, d, id, lat);
        vec++;
        if (d !== 32'h0 || lat !== 33) begin
            bad++;
            $display("FAIL udiv_big: data=%h lat=%0d want 0 33", d, lat);
        end
        do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 4'd2, d, id, lat);
        vec++;
        if (d !== 32'hF) begin
            bad++;
            $display("FAIL udiv_max_r: data=%h want f", d);
        end
    endtask

    task automatic test_signed;
        logic [31:0] d;
        logic [3:0]  id;
        int          lat;
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 4'd4, d, id, lat);
        vec++;
        if (d !== 32'hFFFF_FFFD || lat !== 33) begin
            bad++;
            $display("FAIL sdiv_q: data=%h lat=%0d want fffffffd 33", d, lat);
        end
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 4'd4, d, id, lat);
        vec++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sdiv_r: data=%h want ffffffff", d);
        end
        do_op(2'b01, 32'd100, 32'hFFFF_FFF9, 4'd6, d, id, lat);
        vec++;
        if (d !== 32'hFFFF_FFF2) begin
            bad++;
            $display("FAIL sdiv_q2: data=%h want fffffff2", d);
        end
        do_op(2'b11, 32'd100, 32'hFFFF_FFF9, 4'd6, d, id, lat);
        vec++;
        if (d !== 32'd2) begin
            bad++;
            $display("FAIL sdiv_r2: data=%h want 2", d);
        end
    endtask

    task automatic test_fast;
        logic [31:0] d;
        logic [3:0]  id;
        int          lat;
        do_op(2'b00, 32'd5, 32'd0, 4'd8, d, id, lat);
        vec++;
        if (d !== 32'hFFFF_FFFF || id !== 4'd8 || lat !== 1) begin
            bad++;
            $display("FAIL div0_q: data=%h id=%0d lat=%0d want ffffffff 8 1", d, id, lat);
        end
        do_op(2'b10, 32'd5, 32'd0, 4'd9, d, id, lat);
        vec++;
        if (d !== 32'd5 || lat !== 1) begin
            bad++;
            $display("FAIL div0_r: data=%h lat=%0d want 5 1", d, lat);
        end
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, d, id, lat);
        vec++;
        if (d !== 32'h8000_0000 || lat !== 1) begin
            bad++;
            $display("FAIL ovf_q: data=%h lat=%0d want 80000000 1", d, lat);
        end
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, d, id, lat);
        vec++;
        if (d !== 32'h0 || id !== 4'd11 || lat !== 1) begin
            bad++;
            $display("FAIL ovf_r: data=%h id=%0d lat=%0d want 0 11 1", d, id, lat);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        offer(2'b00, 32'd1000, 32'd10, 4'd9);
        wait_bv(lat);
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (bus.wb_BVALID !== 1'b1 || bus.wb_BDATA !== 32'd100 ||
                bus.wb_id !== 4'd9 || bus.fu_AREADY !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: bv=%b data=%0d id=%0d ardy=%b want 1 100 9 0",
                         i, bus.wb_BVALID, bus.wb_BDATA, bus.wb_id, bus.fu_AREADY);
            end
            @(negedge clk);
        end
        consume();
        vec++;
        if (bus.wb_BVALID !== 1'b0 || bus.fu_AREADY !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: bv=%b ardy=%b want 0 1",
                     bus.wb_BVALID, bus.fu_AREADY);
        end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        logic [3:0]  id;
        int          lat;
        logic        stale;
        offer(2'b00, 32'd1000, 32'd3, 4'd1);
        repeat (9) @(negedge clk);
        flush          = 1'b1;
        bus.fu_AVALID  = 1'b1;
        bus.fu_uop     = 2'b00;
        bus.fu_rs1_dat = 32'd8;
        bus.fu_rs2_dat = 32'd2;
        bus.fu_id      = 4'd2;
        @(negedge clk);
        flush         = 1'b0;
        bus.fu_AVALID = 1'b0;
        vec++;
        if (bus.fu_AREADY !== 1'b1 || bus.wb_BVALID !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: ardy=%b bv=%b want 1 0",
                     bus.fu_AREADY, bus.wb_BVALID);
        end
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_BVALID || !bus.fu_AREADY) stale = 1'b1;
        end
        vec++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL flush_stale: busy_seen=%b want 0", stale);
        end
        do_op(2'b00, 32'd50, 32'd5, 4'd6, d, id, lat);
        vec++;
        if (d !== 32'd10 || id !== 4'd6 || lat !== 33) begin
            bad++;
            $display("FAIL flush_next: data=%0d id=%0d lat=%0d want 10 6 33", d, id, lat);
        end
    endtask

    task automatic test_rst_done;
        int lat;
        offer(2'b00, 32'd50, 32'd5, 4'd7);
        wait_bv(lat);
        vec++;
        if (bus.wb_BVALID !== 1'b1 || bus.wb_BDATA !== 32'd10) begin
            bad++;
            $display("FAIL rstd_pre: bv=%b data=%0d want 1 10",
                     bus.wb_BVALID, bus.wb_BDATA);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if (bus.wb_BVALID !== 1'b0 || bus.wb_BDATA !== 32'h0 ||
            bus.wb_id !== 4'h0 || bus.fu_AREADY !== 1'b1) begin
            bad++;
            $display("FAIL rstd_post: bv=%b data=%h id=%h ardy=%b want 0 0 0 1",
                     bus.wb_BVALID, bus.wb_BDATA, bus.wb_id, bus.fu_AREADY);
        end
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        bus.fu_AVALID  = 1'b0;
        bus.fu_uop     = '0;
        bus.fu_rs1_dat = '0;
        bus.fu_rs2_dat = '0;
        bus.fu_id      = '0;
        bus.wb_BREADY  = 1'b0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_fast();
        test_backpressure();
        test_flush();
        test_rst_done();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/ncpu32k_idiv.md
# ncpu32k_idiv

Iterative 32-bit integer divider functional unit. It is the consumer end of the issue-queue-to-FU handshake: it accepts one ready micro-op with both operand values and its ROB id, computes the quotient or remainder over 32 cycles, and presents the result on a writeback channel toward the bypass network and ROB. One operation is in flight at a time, and a flush aborts it.

## Interface
Parameters:
- CONFIG_ROB_DEPTH_LOG2, 4: width of the ROB id carried through.
- UOP_WIDTH, 2: micro-op width.
  - bit0 = signed (1) / unsigned (0).
  - bit1 = remainder (1) / quotient (0).
  - Any higher bits are ignored.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_flush  in  1  abort the in-flight operation and drop the pending result.
- i_fu_AVALID  in  1  operation offered.
- o_fu_AREADY  out  1  unit can accept an operation.
- i_fu_id  in  CONFIG_ROB_DEPTH_LOG2  ROB id of the offered operation.
- i_fu_uop  in  UOP_WIDTH  operation select.
- i_fu_rs1_dat  in  `NCPU_DW  dividend.
- i_fu_rs2_dat  in  `NCPU_DW  divisor.
- o_wb_BVALID  out  1  result valid.
- i_wb_BREADY  in  1  result consumed.
- o_wb_BDATA  out  `NCPU_DW  result.
- o_wb_id  out  CONFIG_ROB_DEPTH_LOG2  ROB id of the result.

## Operation
States:
- IDLE: o_fu_AREADY=1, o_wb_BVALID=0.
- CALC: 32 iterations.
- DONE: o_wb_BVALID=1.

Transitions:
- Accept: i_fu_AVALID & o_fu_AREADY & ~i_flush. The unit latches id, uop, and operand magnitudes. Signed mode uses two's-complement absolute values. It also latches the quotient sign (rs1[31]^rs2[31], signed only) and the remainder sign (rs1[31], signed only).
- Fast path, taken at accept and going straight to DONE:
  - Divisor==0: quotient = 32'hFFFFFFFF, remainder = rs1.
  - Signed, rs1==32'h80000000 and rs2==32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0.
- Normal path: IDLE→CALC with a 5-bit counter at 0.
- CALC iteration (restoring division):
  - Form a 33-bit partial remainder {rem[31:0], dividend MSB} and subtract the zero-extended divisor.
  - If the result is non-negative, keep it and shift in a quotient bit of 1. Otherwise keep the old value and shift in 0.
  - The counter increments each cycle. When it reaches 31 the state moves to DONE.
- Result on entry to DONE: select quotient or remainder per uop bit1, then negate in two's complement if the latched sign bit applies. Register into o_wb_BDATA.
- DONE→IDLE on i_wb_BREADY. o_wb_BDATA and o_wb_id hold stable while BVALID=1 and BREADY=0.
- Flush: from any state → IDLE on the next edge, with o_wb_BVALID=0 on that edge. An offer in the same cycle as i_flush is not accepted.
- Reset: state IDLE, o_wb_BVALID=0, o_wb_BDATA=0, o_wb_id=0, counter=0. o_fu_AREADY=1 after reset.
- All arithmetic is unsigned 32/33-bit internally. Sign handling happens only at accept and at result formation.

## Timing
- o_fu_AREADY is combinational from state (IDLE only). It does not depend on i_fu_AVALID.
- Accept edge T, normal path:
  - CALC during cycles T+1..T+32.
  - o_wb_BVALID=1 from cycle T+33.
- Accept edge T, fast path: o_wb_BVALID=1 from cycle T+1.
- Result handshake at edge R: o_wb_BVALID=0 and o_fu_AREADY=1 in cycle R+1. There is no accept in cycle R.
- Minimum initiation interval: 34 cycles (normal path) and 2 cycles (fast path).
- i_flush during CALC: the counter reset and data are discarded. The next accept is possible in the cycle after the flush.
- i_flush together with i_wb_BREADY in DONE: the unit goes to IDLE either way. The result counts as delivered only if the consumer sampled BVALID&BREADY. The flush dominates any further output.
- rst mid-CALC or mid-DONE: identical to the reset values on the next edge. No stale BVALID.

## Test plan
- Unsigned divide, uop=2'b00, rs1=100, rs2=7, id=3, BREADY=1:
  - o_wb_BDATA=14, o_wb_id=3, BVALID exactly 33 cycles after accept.
  - Repeat with uop=2'b10: BDATA=2.
- Signed divide, uop=2'b01, rs1=-7 (32'hFFFFFFF9), rs2=2: BDATA=32'hFFFFFFFD (-3). With uop=2'b11: BDATA=32'hFFFFFFFF (-1).
- Divide by zero and overflow, both with BVALID one cycle after accept:
  - rs1=5, rs2=0, uop=00: BDATA=32'hFFFFFFFF.
  - rs1=5, rs2=0, uop=10: BDATA=5.
  - Signed rs1=32'h80000000, rs2=32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
- Backpressure: i_wb_BREADY low for 5 cycles after BVALID rises.
  - BDATA and id stay constant and o_fu_AREADY stays 0.
  - After the BREADY pulse, BVALID drops and AREADY rises the next cycle.
- Flush at CALC cycle 10, with a new op offered the same cycle:
  - The new op is not accepted, and the unit is in IDLE the next cycle.
  - A later op 50/5 returns 10 with correct latency, and no stale result ever appears.
- rst asserted during DONE with BREADY=0: next cycle BVALID=0, BDATA=0, id=0, AREADY=1.
